// File: rtl/dab_param_scheduler.sv
// DAB modulator configuration scheduler: validates setpoints, converts them to clock
// counts with one shared restoring divider, commits at period boundaries, sequences run/stop.
module dab_param_scheduler #(
    parameter int unsigned FS_MIN = 1000,
    parameter int unsigned FS_MAX = 150000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cfg_valid,
    output logic               cfg_ready,
    input  logic signed [8:0]  t1,
    input  logic signed [8:0]  t2,
    input  logic signed [8:0]  phi,
    input  logic        [18:0] fs_DAB,
    input  logic               enable,
    input  logic               estop,
    input  logic               period_end,
    output logic signed [18:0] tau1_cuentas,
    output logic signed [18:0] tau2_cuentas,
    output logic signed [18:0] phi_cuentas,
    output logic signed [18:0] pi_cuentas,
    output logic               sync,
    output logic               run,
    output logic               fault,
    output logic               err
);

    localparam logic [18:0] FS_LO  = 19'(FS_MIN);
    localparam logic [18:0] FS_HI  = 19'(FS_MAX);
    localparam logic [25:0] K_TAU  = 26'd196078;
    localparam logic [25:0] PI_DVD = 26'd50000000;

    typedef enum logic [1:0] {C_IDLE, C_CHECK, C_DIV, C_PEND} cfg_state_t;
    typedef enum logic [1:0] {R_STOP, R_SYNC, R_RUN, R_FAULT} run_state_t;

    cfg_state_t        cfg_st;
    run_state_t        run_st;
    logic signed [8:0] t1_q, t2_q, phi_q;
    logic [18:0]       fs_q;
    logic [25:0]       dvd, quo, quo_nx;
    logic [19:0]       rem, rem_sh, rem_nx;
    logic [4:0]        bit_cnt;
    logic [1:0]        div_idx;
    logic signed [18:0] sh_tau1, sh_tau2, sh_phi, sh_pi;
    logic              cfg_loaded;
    logic [7:0]        phi_mag;
    logic              q_bit, bad_cfg, stopped, commit;
    logic [18:0]       result;

    function automatic logic [25:0] dividend(input logic [1:0] idx, input logic [7:0] a,
                                             input logic [7:0] b, input logic [7:0] c);
        case (idx)
            2'd0:    return {18'd0, a} * K_TAU;
            2'd1:    return {18'd0, b} * K_TAU;
            2'd2:    return {18'd0, c} * K_TAU;
            default: return PI_DVD;
        endcase
    endfunction

    always_comb begin
        phi_mag = phi_q[8] ? 8'(-phi_q) : phi_q[7:0];
        rem_sh  = {rem[18:0], dvd[25]};
        q_bit   = rem_sh >= {1'b0, fs_q};
        rem_nx  = q_bit ? rem_sh - {1'b0, fs_q} : rem_sh;
        quo_nx  = {quo[24:0], q_bit};
        result  = (div_idx == 2'd2 && phi_q[8]) ? 19'(-quo_nx[18:0]) : quo_nx[18:0];
        bad_cfg = t1_q[8] | t2_q[8] | (phi_q[8] && phi_q[7:0] == 8'd0)
                | (fs_q < FS_LO) | (fs_q > FS_HI);
        stopped = (run_st == R_STOP) || (run_st == R_FAULT);
        // While running, estop on a boundary cycle wins over the commit; FAULT then commits.
        commit  = (cfg_st == C_PEND) && (stopped || (period_end && !estop));
        cfg_ready = (cfg_st == C_IDLE) && !err;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cfg_st <= C_IDLE;
            t1_q <= '0; t2_q <= '0; phi_q <= '0; fs_q <= '0;
            dvd <= '0; quo <= '0; rem <= '0; bit_cnt <= '0; div_idx <= '0;
            sh_tau1 <= '0; sh_tau2 <= '0; sh_phi <= '0; sh_pi <= '0;
            tau1_cuentas <= '0; tau2_cuentas <= '0; phi_cuentas <= '0; pi_cuentas <= '0;
            cfg_loaded <= 1'b0;
            err <= 1'b0;
        end else begin
            err <= 1'b0;
            case (cfg_st)
                C_IDLE: if (cfg_valid && cfg_ready) begin
                    t1_q <= t1; t2_q <= t2; phi_q <= phi; fs_q <= fs_DAB;
                    cfg_st <= C_CHECK;
                end
                C_CHECK: if (bad_cfg) begin
                    err    <= 1'b1;
                    cfg_st <= C_IDLE;
                end else begin
                    dvd     <= dividend(2'd0, t1_q[7:0], t2_q[7:0], phi_mag);
                    rem     <= '0;
                    quo     <= '0;
                    bit_cnt <= '0;
                    div_idx <= '0;
                    cfg_st  <= C_DIV;
                end
                C_DIV: begin
                    rem     <= rem_nx;
                    quo     <= quo_nx;
                    dvd     <= {dvd[24:0], 1'b0};
                    bit_cnt <= bit_cnt + 5'd1;
                    if (bit_cnt == 5'd25) begin
                        case (div_idx)
                            2'd0:    sh_tau1 <= result;
                            2'd1:    sh_tau2 <= result;
                            2'd2:    sh_phi  <= result;
                            default: sh_pi   <= result;
                        endcase
                        bit_cnt <= '0;
                        rem     <= '0;
                        quo     <= '0;
                        if (div_idx == 2'd3) begin
                            cfg_st <= C_PEND;
                        end else begin
                            div_idx <= div_idx + 2'd1;
                            dvd     <= dividend(div_idx + 2'd1, t1_q[7:0], t2_q[7:0], phi_mag);
                        end
                    end
                end
                C_PEND: if (commit) begin
                    tau1_cuentas <= sh_tau1;
                    tau2_cuentas <= sh_tau2;
                    phi_cuentas  <= sh_phi;
                    pi_cuentas   <= sh_pi;
                    cfg_loaded   <= 1'b1;
                    cfg_st       <= C_IDLE;
                end
                default: cfg_st <= C_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            run_st <= R_STOP;
            sync   <= 1'b0;
            run    <= 1'b0;
            fault  <= 1'b0;
        end else begin
            sync <= 1'b0;
            if (estop) begin
                run_st <= R_FAULT;
                run    <= 1'b0;
                fault  <= 1'b1;
            end else begin
                case (run_st)
                    R_STOP: if (enable && cfg_loaded) begin
                        run_st <= R_SYNC;
                        sync   <= 1'b1;
                        run    <= 1'b1;
                    end
                    R_SYNC: begin
                        run_st <= R_RUN;
                        run    <= 1'b1;
                    end
                    R_RUN: if (!enable) begin
                        run_st <= R_STOP;
                        run    <= 1'b0;
                    end
                    R_FAULT: if (!enable) begin
                        run_st <= R_STOP;
                        fault  <= 1'b0;
                    end
                    default: run_st <= R_STOP;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_dab_param_scheduler.sv
// Directed bench for dab_param_scheduler: hand-computed counts, handshake timing,
// run/sync/fault sequencing and mid-division reset.
module tb_dab_param_scheduler;

    logic               clk = 1'b0;
    logic               rst;
    logic               cfg_valid;
    logic               cfg_ready;
    logic signed [8:0]  t1, t2, phi;
    logic        [18:0] fs_DAB;
    logic               enable, estop, period_end;
    logic signed [18:0] tau1_cuentas, tau2_cuentas, phi_cuentas, pi_cuentas;
    logic               sync, run, fault, err;

    int checks = 0;
    int errors = 0;
    int sync_cnt = 0;
    int err_cnt = 0;

    dab_param_scheduler #(.FS_MIN(1000), .FS_MAX(150000)) dut (
        .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .t1(t1), .t2(t2), .phi(phi), .fs_DAB(fs_DAB),
        .enable(enable), .estop(estop), .period_end(period_end),
        .tau1_cuentas(tau1_cuentas), .tau2_cuentas(tau2_cuentas),
        .phi_cuentas(phi_cuentas), .pi_cuentas(pi_cuentas),
        .sync(sync), .run(run), .fault(fault), .err(err)
    );

    always #10 clk = ~clk;

    always @(posedge clk) begin
        if (sync) sync_cnt++;
        if (err)  err_cnt++;
    end

    task automatic check(input string tag, input logic signed [31:0] got,
                         input logic signed [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Returns at the negedge right after the handshake edge E0.
    task automatic offer(input int a, input int b, input int p, input int f);
        @(negedge clk);
        check("ready_before_offer", 32'(cfg_ready), 1);
        cfg_valid = 1'b1;
        t1 = 9'(a); t2 = 9'(b); phi = 9'(p); fs_DAB = 19'(f);
        @(negedge clk);
        cfg_valid = 1'b0;
    endtask

    task automatic check_counts(input string tag, input int a, input int b,
                                input int p, input int q);
        check({tag, "_tau1"}, 32'(tau1_cuentas), a);
        check({tag, "_tau2"}, 32'(tau2_cuentas), b);
        check({tag, "_phi"},  32'(phi_cuentas),  p);
        check({tag, "_pi"},   32'(pi_cuentas),   q);
    endtask

    int rej_t1[3]  = '{100, 100, -1};
    int rej_phi[3] = '{10, -256, 10};
    int rej_fs[3]  = '{999, 100000, 100000};

    initial begin
        #1ms;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b0; cfg_valid = 1'b0; t1 = '0; t2 = '0; phi = '0; fs_DAB = '0;
        enable = 1'b0; estop = 1'b0; period_end = 1'b0;
        cyc(2);
        check_counts("rst", 0, 0, 0, 0);
        check("rst_sync", 32'(sync), 0);
        check("rst_run", 32'(run), 0);
        check("rst_fault", 32'(fault), 0);
        check("rst_err", 32'(err), 0);
        check("rst_ready", 32'(cfg_ready), 1);
        rst = 1'b1;

        // Stopped load
        offer(128, 64, -50, 100000);
        cyc(105);
        check("stop_ready_busy", 32'(cfg_ready), 0);
        check_counts("stop_pre", 0, 0, 0, 0);
        cyc(1);
        check_counts("stop", 250, 125, -98, 500);
        check("stop_ready_back", 32'(cfg_ready), 1);
        check("stop_no_err", err_cnt, 0);

        // Max-frequency boundary, then start
        offer(255, 0, 255, 150000);
        cyc(106);
        check_counts("fmax", 333, 0, 333, 333);
        check("fmax_run_off", 32'(run), 0);
        enable = 1'b1;
        cyc(1);
        check("start_sync", 32'(sync), 1);
        check("start_run", 32'(run), 1);
        cyc(1);
        check("start_sync_low", 32'(sync), 0);
        check("start_run_hold", 32'(run), 1);
        check("start_sync_cnt", sync_cnt, 1);

        // Rejections
        for (int i = 0; i < 3; i++) begin
            offer(rej_t1[i], 50, rej_phi[i], rej_fs[i]);
            check("rej_err_e0", 32'(err), 0);
            cyc(1);
            check("rej_err", 32'(err), 1);
            check("rej_ready_low", 32'(cfg_ready), 0);
            cyc(1);
            check("rej_err_clear", 32'(err), 0);
            check("rej_ready_back", 32'(cfg_ready), 1);
            check_counts("rej", 333, 0, 333, 333);
        end
        check("rej_err_cnt", err_cnt, 3);

        // Running update; a busy-time offer must be ignored
        offer(100, 100, 0, 50000);
        cyc(10);
        cfg_valid = 1'b1; t1 = 9'sd10; t2 = 9'sd10; phi = 9'sd10; fs_DAB = 19'd100000;
        cyc(1);
        cfg_valid = 1'b0;
        cyc(95 + 300);
        check_counts("run_hold", 333, 0, 333, 333);
        check("run_ready_pend", 32'(cfg_ready), 0);
        period_end = 1'b1;
        cyc(1);
        period_end = 1'b0;
        check_counts("run_commit", 392, 392, 0, 1000);
        check("run_commit_ready", 32'(cfg_ready), 1);
        check("run_commit_run", 32'(run), 1);
        check("run_commit_sync", sync_cnt, 1);

        // Emergency stop coinciding with the boundary
        offer(64, 50, -100, 100000);
        cyc(110);
        estop = 1'b1; period_end = 1'b1;
        cyc(1);
        period_end = 1'b0;
        check("estop_run", 32'(run), 0);
        check("estop_fault", 32'(fault), 1);
        check_counts("estop_nocommit", 392, 392, 0, 1000);
        cyc(1);
        check_counts("estop_commit", 125, 98, -196, 500);
        check("estop_ready", 32'(cfg_ready), 1);
        estop = 1'b0;
        cyc(3);
        check("fault_hold", 32'(fault), 1);
        check("fault_run", 32'(run), 0);
        enable = 1'b0;
        cyc(1);
        check("fault_clear", 32'(fault), 0);
        enable = 1'b1;
        cyc(1);
        check("resync", 32'(sync), 1);
        check("resync_run", 32'(run), 1);
        cyc(1);
        check("resync_cnt", sync_cnt, 2);

        // Reset mid-division
        offer(255, 255, 255, 100000);
        cyc(49);
        #5 rst = 1'b0;
        #1;
        check_counts("mrst", 0, 0, 0, 0);
        check("mrst_run", 32'(run), 0);
        check("mrst_sync", 32'(sync), 0);
        check("mrst_fault", 32'(fault), 0);
        check("mrst_ready", 32'(cfg_ready), 1);
        @(negedge clk);
        rst = 1'b1;
        cyc(20);
        check("mrst_no_sync", sync_cnt, 2);
        check("mrst_no_run", 32'(run), 0);
        offer(128, 64, -50, 100000);
        cyc(106);
        check_counts("mrst_reload", 250, 125, -98, 500);
        cyc(1);
        check("mrst_sync_after_load", 32'(sync), 1);
        cyc(1);
        check("final_sync_cnt", sync_cnt, 3);
        check("final_err_cnt", err_cnt, 3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dab_param_scheduler.md
# dab_param_scheduler

Configuration scheduler for the DAB modulator. Accepts duty/phase/frequency setpoints (t1, t2, phi, fs_DAB) through a valid/ready handshake and validates them. Converts them to clock-count values (tau1, tau2, phi, pi counts) with one shared sequential divider. Commits them atomically to the modulator only at a switching-period boundary, and sequences modulator start (sync pulse), run gating and emergency stop.

## Interface
- FS_MIN, 1000: minimum accepted fs_DAB in Hz; keeps 2*pi+phi counts inside signed 19 bits.
- FS_MAX, 150000: maximum accepted fs_DAB in Hz.
- clk  input  1  system clock, 50 MHz.
- rst  input  1  reset: asynchronous, active-low.
- cfg_valid  input  1  setpoint offer.
- cfg_ready  output  1  high only in state IDLE.
- t1, t2  input  9 signed  pulse widths; legal range 0..255.
- phi  input  9 signed  phase shift; legal range -255..255.
- fs_DAB  input  19  switching frequency in Hz.
- enable  input  1  run request (level).
- estop  input  1  emergency stop (level, synchronous).
- period_end  input  1  one-cycle pulse from the modulator at primary counter wrap.
- tau1_cuentas, tau2_cuentas, phi_cuentas, pi_cuentas  output  19 signed  active (committed) counts.
- sync  output  1  one-cycle modulator start pulse.
- run  output  1  modulator output gate.
- fault  output  1  latched estop indication.
- err  output  1  one-cycle pulse: offered setpoint rejected.

## Operation
- Config FSM states:
  - IDLE: cfg_ready=1. On cfg_valid, latch the inputs → CHECK.
  - CHECK: if any input is out of range (t1<0, t2<0, phi=-256, fs_DAB<FS_MIN or >FS_MAX), pulse err and go to IDLE. Active counts are unchanged. Otherwise → DIV.
  - DIV: one restoring divider, 26-bit unsigned dividend, fs_DAB divisor, 1 quotient bit per cycle.
    - Four divisions in this order: |t1|*196078, |t2|*196078, |phi|*196078, 50000000.
    - Quotients truncate (floor of magnitude). phi result is negated when phi<0.
    - Results go to shadow registers. After the 4th division → PEND.
  - PEND: commit shadow → active, set cfg_loaded, → IDLE.
    - If run FSM is STOP or FAULT: commit on the first PEND cycle.
    - If run FSM is SYNC or RUN: commit on the cycle period_end=1 and estop=0.
- Run FSM states:
  - STOP: run=0. Go to SYNC when enable & cfg_loaded & !estop.
  - SYNC: sync=1, run=1 for one cycle → RUN.
  - RUN: run=1. estop → FAULT; otherwise !enable → STOP.
  - FAULT: run=0, fault=1. Go to STOP when !enable & !estop.
- estop in any run state → FAULT on the next edge. It has priority over enable, sync and a pending commit.
- The pending config is retained through FAULT. Because FAULT counts as stopped, the retained config commits on the next PEND cycle.
- Reset in any state, including mid-division: both FSMs to IDLE/STOP, cfg_loaded=0, shadow regs cleared.

## Timing
- Reset values: all count outputs 0; sync=0, run=0, fault=0, err=0; cfg_ready=1 (IDLE).
- E0 = handshake edge.
  - CHECK resolves at E1; err is high during the cycle after E1.
  - DIV occupies E2..E105 (4×26 iterations).
  - Stopped case: commit at E106; the new counts are visible after E106, and cfg_ready returns at the same edge.
- Running case: commit at the first period_end edge at or after E106, so all four counts change at the same edge.
- sync is asserted exactly one cycle after cfg_loaded & enable are first both high in STOP, and never while in RUN.
- cfg_valid while cfg_ready=0 is ignored, and the setpoint is not captured.
- period_end outside PEND has no effect.

## Test plan
- Stopped load: fs=100000, t1=128, t2=64, phi=-50 → at E106, tau1=250, tau2=125, phi=-98, pi=500; err never pulses.
- Max-frequency boundary: fs=150000, t1=255, t2=0, phi=255 → tau1=333, tau2=0, phi=333, pi=333. Then raise enable → sync high for exactly 1 cycle, run=1 from that cycle.
- Rejection: fs=999, then phi=-256, then t1=-1 → err pulses once per offer at E1+1; counts unchanged; cfg_ready back at E2.
- Running update: while in RUN, offer fs=50000, t1=100, t2=100, phi=0.
  - Hold period_end low for 300 cycles → old counts held.
  - Pulse period_end → at that edge tau1=tau2=392, phi=0, pi=1000, no sync.
- Emergency: in RUN with an update in PEND, assert estop together with period_end.
  - → run=0, fault=1, no commit on that edge; commit follows on the next edge.
  - Drop estop with enable high → stays FAULT. Drop enable → STOP; raise enable → new sync.
- Reset mid-DIV (rst low at E50): all outputs return to reset values immediately; enable high afterwards produces no sync until a new config is committed.
